// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronize, debounce and classify one push-button into press/click/long_press
module button_debouncer #(
    parameter int   CLK_FREQUENCY          = 100000000,
    parameter logic BUTTON_INPUT_LEVEL     = 1'b1,
    parameter logic CLICK_OUTPUT_LEVEL     = 1'b1,
    parameter int   CLICK_DEBOUNCE_MS      = 10,
    parameter logic PRESS_OUTPUT_LEVEL     = 1'b1,
    parameter int   LONG_PRESS_DURATION_MS = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic usr_btn,
    output logic click,
    output logic press,
    output logic long_press
);

    // Debounce window N and long-press hold time L in clock cycles, both at least one cycle
    localparam int D_RAW = CLK_FREQUENCY / 1000 * CLICK_DEBOUNCE_MS;
    localparam int N     = (D_RAW > 1) ? D_RAW : 1;
    localparam int L_RAW = CLK_FREQUENCY / 1000 * LONG_PRESS_DURATION_MS;
    localparam int L     = (L_RAW > 1) ? L_RAW : 1;
    localparam int DW    = $clog2(N + 1);
    localparam int HW    = $clog2(L + 1);

    localparam logic [DW-1:0] D_LAST = DW'(N - 1);
    localparam logic [HW-1:0] H_LAST = HW'(L - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(L);

    logic          sync0;
    logic          sync1;
    logic          raw;
    logic          stable;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;

    logic accept;
    logic stable_next;
    logic rise;
    logic hold_done;

    // A new level is accepted on the N-th consecutive cycle it differs from the debounced one
    assign accept      = (raw != stable) && (dcnt == D_LAST);
    assign stable_next = accept ? raw : stable;
    assign rise        = accept && raw;
    // The hold counter is about to reach L: this is the single long-press cycle
    assign hold_done   = stable && (hcnt == H_LAST);

    // Two-flop synchronizer followed by a registered "is pressed" flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync0 <= ~BUTTON_INPUT_LEVEL;
            sync1 <= ~BUTTON_INPUT_LEVEL;
            raw   <= 1'b0;
        end else begin
            sync0 <= usr_btn;
            sync1 <= sync0;
            raw   <= (sync1 == BUTTON_INPUT_LEVEL);
        end
    end

    // Debounce: count consecutive differing cycles, any agreement restarts the count
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= 1'b0;
            dcnt   <= '0;
        end else if (raw == stable) begin
            dcnt <= '0;
        end else if (dcnt == D_LAST) begin
            stable <= raw;
            dcnt   <= '0;
        end else begin
            dcnt <= dcnt + DW'(1);
        end
    end

    // Hold counter: cleared while released, saturates at L so long_press fires once per press
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt <= '0;
        end else if (!stable) begin
            hcnt <= '0;
        end else if (hcnt < H_MAX) begin
            hcnt <= hcnt + HW'(1);
        end
    end

    // Output flops, updated on the same edge as the debounced state they describe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            press      <= ~PRESS_OUTPUT_LEVEL;
            click      <= ~CLICK_OUTPUT_LEVEL;
            long_press <= ~CLICK_OUTPUT_LEVEL;
        end else begin
            press      <= stable_next ? PRESS_OUTPUT_LEVEL : ~PRESS_OUTPUT_LEVEL;
            click      <= rise ? CLICK_OUTPUT_LEVEL : ~CLICK_OUTPUT_LEVEL;
            long_press <= hold_done ? CLICK_OUTPUT_LEVEL : ~CLICK_OUTPUT_LEVEL;
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - self-checking bench for button_debouncer
`timescale 1ns/1ps
module tb_button_debouncer;

    localparam int N = 10;
    localparam int L = 50;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_ac;
    logic rst_b;
    logic btn_a;
    logic btn_b;
    logic click_a, press_a, long_a;
    logic click_b, press_b, long_b;
    logic click_c, press_c, long_c;

    // Test-plan parameters, all levels active-high
    button_debouncer #(
        .CLK_FREQUENCY(10000), .BUTTON_INPUT_LEVEL(1'b1), .CLICK_OUTPUT_LEVEL(1'b1),
        .CLICK_DEBOUNCE_MS(1), .PRESS_OUTPUT_LEVEL(1'b1), .LONG_PRESS_DURATION_MS(5)
    ) dut_a (
        .clk(clk), .reset(rst_ac), .usr_btn(btn_a),
        .click(click_a), .press(press_a), .long_press(long_a)
    );

    // Active-low button with zero delays (N=1, L=1)
    button_debouncer #(
        .CLK_FREQUENCY(10000), .BUTTON_INPUT_LEVEL(1'b0), .CLICK_OUTPUT_LEVEL(1'b1),
        .CLICK_DEBOUNCE_MS(0), .PRESS_OUTPUT_LEVEL(1'b1), .LONG_PRESS_DURATION_MS(0)
    ) dut_b (
        .clk(clk), .reset(rst_b), .usr_btn(btn_b),
        .click(click_b), .press(press_b), .long_press(long_b)
    );

    // Same stimulus as dut_a, outputs active-low
    button_debouncer #(
        .CLK_FREQUENCY(10000), .BUTTON_INPUT_LEVEL(1'b1), .CLICK_OUTPUT_LEVEL(1'b0),
        .CLICK_DEBOUNCE_MS(1), .PRESS_OUTPUT_LEVEL(1'b0), .LONG_PRESS_DURATION_MS(5)
    ) dut_c (
        .clk(clk), .reset(rst_ac), .usr_btn(btn_a),
        .click(click_c), .press(press_c), .long_press(long_c)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: input delayed by three edges, accepted when the last N seen values
    // all disagree with the debounced level; long press when the level has been high for
    // exactly the last L edges after having been low just before them.
    logic pipe[$];
    logic win[$];
    logic hist[$];
    logic m_stable;
    logic exp_click;
    logic exp_long;

    task automatic model_reset();
        pipe = {1'b0, 1'b0, 1'b0};
        win.delete();
        hist.delete();
        for (int i = 0; i <= L; i++) hist.push_back(1'b0);
        m_stable  = 1'b0;
        exp_click = 1'b0;
        exp_long  = 1'b0;
    endtask

    task automatic model_edge(input logic b);
        logic seen;
        logic nxt;
        bit   all_diff;
        if (rst_ac) begin
            model_reset();
            return;
        end
        seen = pipe.pop_front();
        pipe.push_back(b);
        win.push_back(seen);
        if (win.size() > N) void'(win.pop_front());
        all_diff = (win.size() == N);
        foreach (win[i]) if (win[i] == m_stable) all_diff = 1'b0;
        nxt = all_diff ? ~m_stable : m_stable;
        exp_click = nxt & ~m_stable;
        exp_long = (hist[0] == 1'b0);
        for (int i = 1; i <= L; i++) if (hist[i] != 1'b1) exp_long = 1'b0;
        void'(hist.pop_front());
        hist.push_back(nxt);
        m_stable = nxt;
    endtask

    task automatic cmp_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic cmp_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        cmp_bit({tag, "_press_a"}, press_a, m_stable);
        cmp_bit({tag, "_click_a"}, click_a, exp_click);
        cmp_bit({tag, "_long_a"},  long_a,  exp_long);
        cmp_bit({tag, "_press_c"}, press_c, ~m_stable);
        cmp_bit({tag, "_click_c"}, click_c, ~exp_click);
        cmp_bit({tag, "_long_c"},  long_c,  ~exp_long);
    endtask

    // Drive at the falling edge, advance the model on the rising edge, check at the next falling edge
    task automatic tick(input logic b, input string tag);
        btn_a = b;
        @(posedge clk);
        model_edge(b);
        @(negedge clk);
        check_model(tag);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, "idle");
    endtask

    initial begin
        int   click_edge;
        int   click_c_edge;
        int   long_edge;
        int   fall_edge;
        int   n_click;
        int   n_long;
        int   n_any;
        logic prev_press;
        logic val;
        int   len;

        rst_ac = 1'b1;
        rst_b  = 1'b1;
        btn_a  = 1'b0;
        btn_b  = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_model("reset");
        cmp_bit("reset_press_b", press_b, 1'b0);
        cmp_bit("reset_click_b", click_b, 1'b0);
        cmp_bit("reset_long_b",  long_b,  1'b0);
        rst_ac = 1'b0;
        rst_b  = 1'b0;
        idle(5);

        // Scenario 1: continuous hold
        click_edge = -1; click_c_edge = -1; long_edge = -1; n_click = 0; n_long = 0;
        for (int k = 0; k < 100; k++) begin
            tick(1'b1, "s1");
            if (click_a === 1'b1) begin n_click++; if (click_edge < 0) click_edge = k; end
            if (long_a === 1'b1) begin n_long++; if (long_edge < 0) long_edge = k; end
            if (click_c === 1'b0 && click_c_edge < 0) click_c_edge = k;
        end
        cmp_int("s1_click_edge", click_edge, 12);
        cmp_int("s1_long_edge", long_edge, 62);
        cmp_int("s1_click_count", n_click, 1);
        cmp_int("s1_long_count", n_long, 1);
        cmp_int("s1_click_c_edge", click_c_edge, 12);
        cmp_bit("s1_press_held", press_a, 1'b1);
        idle(20);

        // Scenario 2: 5-cycle glitch is rejected
        n_any = 0;
        for (int k = 0; k < 35; k++) begin
            tick(k < 5, "s2");
            if (press_a === 1'b1 || click_a === 1'b1 || long_a === 1'b1) n_any++;
        end
        cmp_int("s2_activity", n_any, 0);

        // Scenario 3: 30-cycle press then release
        click_edge = -1; fall_edge = -1; n_long = 0; prev_press = 1'b0;
        for (int k = 0; k < 60; k++) begin
            tick(k < 30, "s3");
            if (click_a === 1'b1 && click_edge < 0) click_edge = k;
            if (long_a === 1'b1) n_long++;
            if (prev_press === 1'b1 && press_a === 1'b0 && fall_edge < 0) fall_edge = k;
            prev_press = press_a;
        end
        cmp_int("s3_click_edge", click_edge, 12);
        cmp_int("s3_long_count", n_long, 0);
        cmp_int("s3_release_edge", fall_edge, 42);
        idle(10);

        // Scenario 4: asynchronous reset while held, button still held afterwards
        for (int k = 0; k < 40; k++) tick(1'b1, "s4_hold");
        rst_ac = 1'b1;
        #1;
        cmp_bit("s4_async_press_a", press_a, 1'b0);
        cmp_bit("s4_async_click_a", click_a, 1'b0);
        cmp_bit("s4_async_long_a",  long_a,  1'b0);
        cmp_bit("s4_async_press_c", press_c, 1'b1);
        cmp_bit("s4_async_click_c", click_c, 1'b1);
        cmp_bit("s4_async_long_c",  long_c,  1'b1);
        model_reset();
        for (int k = 40; k < 45; k++) tick(1'b1, "s4_rst");
        rst_ac = 1'b0;
        click_edge = -1;
        for (int k = 45; k < 80; k++) begin
            tick(1'b1, "s4_after");
            if (click_a === 1'b1 && click_edge < 0) click_edge = k;
        end
        cmp_int("s4_click_edge", click_edge, 57);
        idle(20);

        // Scenario 5: active-low button, zero delays
        btn_b = 1'b0;
        for (int k = 0; k < 7; k++) begin
            tick(1'b0, "s5_idle");
            cmp_bit($sformatf("s5_press_b_e%0d", k), press_b, k >= 3);
            cmp_bit($sformatf("s5_click_b_e%0d", k), click_b, k == 3);
            cmp_bit($sformatf("s5_long_b_e%0d", k),  long_b,  k == 4);
        end

        // Randomized bursts with occasional glitches and asynchronous resets
        for (int b = 0; b < 60; b++) begin
            val = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, N) : $urandom_range(1, 70);
            for (int i = 0; i < len; i++) tick(val, "rand");
            if ($urandom_range(0, 14) == 0) begin
                rst_ac = 1'b1;
                model_reset();
                #1;
                check_model("rand_async_rst");
                len = $urandom_range(1, 3);
                for (int i = 0; i < len; i++) tick(val, "rand_rst");
                rst_ac = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
